// File: rtl/fp_matmul_pkg.sv
// rtl/fp_matmul_pkg.sv - state type and fixed-point helpers for fp_matmul_seq
// Define FP_MATMUL_SATURATE_EN to make fx_narrow clamp instead of wrap.
package fp_matmul_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  // Widest accumulator fx_narrow can take; callers sign-extend into it.
  localparam int FX_MAX_W = 128;

  function automatic int acc_width(input int in_w, input int len);
    return 2 * in_w + $clog2(len) + 1;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic logic signed [FX_MAX_W-1:0] fx_narrow(
    input logic signed [FX_MAX_W-1:0] acc,
    input int                         shift,
    input int                         out_w
  );
    logic signed [FX_MAX_W-1:0] v;
`ifdef FP_MATMUL_SATURATE_EN
    logic signed [FX_MAX_W-1:0] hi;
    logic signed [FX_MAX_W-1:0] lo;
`endif
    v = acc >>> shift;
`ifdef FP_MATMUL_SATURATE_EN
    hi = (FX_MAX_W'(1) << (out_w - 1)) - FX_MAX_W'(1);
    lo = ~hi;
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
`else
    v = (v <<< (FX_MAX_W - out_w)) >>> (FX_MAX_W - out_w);
`endif
    return v;
  endfunction

endpackage

// File: rtl/fp_mac_lane.sv
// rtl/fp_mac_lane.sv - one multiply-accumulate lane with fixed-point output conversion
// The output is the converted sum including the current product, so it is valid on the last-k cycle.
module fp_mac_lane
  import fp_matmul_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int LEN   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] i_a,
  input  logic signed [IN_W-1:0] i_b,
  input  logic                   i_en,
  input  logic                   i_clear,
  input  logic                   i_last,
  output logic [OUT_W-1:0]       o_result
);

  localparam int ACC_W = acc_width(IN_W, LEN);
  localparam int SHIFT = IN_W - OUT_W / 2;

  logic signed [2*IN_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod   = i_a * i_b;
  assign w_sum    = r_acc + ACC_W'(w_prod);
  assign o_result = OUT_W'(fx_narrow({{(FX_MAX_W-ACC_W){w_sum[ACC_W-1]}}, w_sum}, SHIFT, OUT_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_last ? '0 : w_sum;
    end
  end

endmodule

// File: rtl/fp_matmul_seq.sv
// rtl/fp_matmul_seq.sv - sequential fixed-point matrix multiplier, LANES MACs time-multiplexed over the output
// Narrowing behaviour follows FP_MATMUL_SATURATE_EN (see fp_matmul_pkg).
module fp_matmul_seq
  import fp_matmul_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int ROW_1             = 8,
  parameter int COL_1             = 4,
  parameter int COL_2             = 8,
  parameter int LANES             = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [INPUT_DATA_WIDTH*ROW_1*COL_1-1:0]      in_1,
  input  logic [INPUT_DATA_WIDTH*COL_1*COL_2-1:0]      in_2,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [OUTPUT_DATA_WIDTH*ROW_1*COL_2-1:0]     out,
  output logic                                         busy
);

  localparam int IW     = INPUT_DATA_WIDTH;
  localparam int OW     = OUTPUT_DATA_WIDTH;
  localparam int N_ELEM = ROW_1 * COL_2;
  localparam int PASSES = ceil_div(N_ELEM, LANES);
  localparam int K_W    = (COL_1 > 1) ? $clog2(COL_1) : 1;
  localparam int P_W    = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_t                    r_state;
  logic [K_W-1:0]            r_k;
  logic [P_W-1:0]            r_pass;
  logic [IW*ROW_1*COL_1-1:0] r_a;
  logic [IW*COL_1*COL_2-1:0] r_b;
  logic [OW*N_ELEM-1:0]      r_out;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_busy;

  logic                      w_accept;
  logic                      w_last_k;
  logic                      w_last_pass;
  int                        w_e [LANES];
  logic                      w_en [LANES];
  logic signed [IW-1:0]      w_a [LANES];
  logic signed [IW-1:0]      w_b [LANES];
  logic [OW-1:0]             w_res [LANES];

  assign w_accept    = r_in_ready && in_valid;
  assign w_last_k    = (r_k == K_W'(COL_1 - 1));
  assign w_last_pass = (r_pass == P_W'(PASSES - 1));

  // Lanes beyond the last element in the final pass get no operands and no enable.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_e[l]  = int'(r_pass) * LANES + l;
      w_en[l] = (r_state == COMPUTE) && (w_e[l] < N_ELEM);
      w_a[l]  = '0;
      w_b[l]  = '0;
      if (w_e[l] < N_ELEM) begin
        w_a[l] = r_a[((w_e[l] / COL_2) * COL_1 + int'(r_k)) * IW +: IW];
        w_b[l] = r_b[(int'(r_k) * COL_2 + (w_e[l] % COL_2)) * IW +: IW];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fp_mac_lane #(
      .IN_W  (IW),
      .OUT_W (OW),
      .LEN   (COL_1)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_a      (w_a[l]),
      .i_b      (w_b[l]),
      .i_en     (w_en[l]),
      .i_clear  (w_accept),
      .i_last   (w_last_k),
      .o_result (w_res[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_pass      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a        <= in_1;
            r_b        <= in_2;
            r_k        <= '0;
            r_pass     <= '0;
            r_state    <= COMPUTE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        COMPUTE: begin
          if (w_last_k) begin
            for (int l = 0; l < LANES; l++) begin
              if (w_en[l]) r_out[w_e[l]*OW +: OW] <= w_res[l];
            end
            r_k <= '0;
            if (w_last_pass) begin
              r_state     <= DONE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_pass <= r_pass + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fp_matmul_seq.sv
// tb/tb_fp_matmul_seq.sv - self-checking bench for fp_matmul_seq, 8-lane and 3-lane builds side by side
`timescale 1ns/1ps
module tb_fp_matmul_seq;

  localparam int IW = 16, OW = 16, R1 = 8, C1 = 4, C2 = 8;
  localparam int AW = IW * R1 * C1, BW = IW * C1 * C2, OUTW = OW * R1 * C2, NE = R1 * C2;
`ifdef FP_MATMUL_SATURATE_EN
  localparam logic [15:0] OVF_7F = 16'h7FFF, OVF_80 = 16'h7FFF;
`else
  localparam logic [15:0] OVF_7F = 16'h0400, OVF_80 = 16'h0000;
`endif

  logic            clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [AW-1:0]   in_1 = '0;
  logic [BW-1:0]   in_2 = '0;
  logic            in_ready_8, out_valid_8, busy_8, in_ready_3, out_valid_3, busy_3;
  logic [OUTW-1:0] out_8, out_3;
  int              n_tests = 0, n_fail = 0;
  int              lat_8, lat_3;

  always #5 clk = ~clk;

  fp_matmul_seq #(.INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW), .ROW_1(R1), .COL_1(C1),
                  .COL_2(C2), .LANES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_8), .in_1(in_1),
    .in_2(in_2), .out_valid(out_valid_8), .out_ready(out_ready), .out(out_8), .busy(busy_8));

  fp_matmul_seq #(.INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW), .ROW_1(R1), .COL_1(C1),
                  .COL_2(C2), .LANES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_3), .in_1(in_1),
    .in_2(in_2), .out_valid(out_valid_3), .out_ready(out_ready), .out(out_3), .busy(busy_3));

  // Reference: plain integer dot products, then floor shift and narrowing.
  function automatic logic [OUTW-1:0] ref_model(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic [OUTW-1:0]      r;
    logic signed [IW-1:0] x, y;
    longint               sum, v;
    r = '0;
    for (int i = 0; i < R1; i++) begin
      for (int j = 0; j < C2; j++) begin
        sum = 0;
        for (int k = 0; k < C1; k++) begin
          x = a[(i*C1+k)*IW +: IW];
          y = b[(k*C2+j)*IW +: IW];
          sum += longint'(x) * longint'(y);
        end
        v = sum >>> (IW - OW/2);
`ifdef FP_MATMUL_SATURATE_EN
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`endif
        r[(i*C2+j)*OW +: OW] = v[OW-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_mat();
    logic [AW-1:0] r;
    for (int w = 0; w < AW/32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AW-1:0] fill_mat(input logic [15:0] v, input bit only0);
    logic [AW-1:0] r;
    for (int e = 0; e < AW/IW; e++) r[e*IW +: IW] = (only0 && e != 0) ? 16'h0000 : v;
    return r;
  endfunction

  function automatic logic [OUTW-1:0] fill_out(input logic [15:0] v0, input logic [15:0] vrest);
    logic [OUTW-1:0] r;
    for (int e = 0; e < NE; e++) r[e*OW +: OW] = (e == 0) ? v0 : vrest;
    return r;
  endfunction

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_mat(input string name, input logic [OUTW-1:0] act, input logic [OUTW-1:0] exp);
    int bad;
    bad = -1;
    for (int e = NE - 1; e >= 0; e--) if (act[e*OW +: OW] !== exp[e*OW +: OW]) bad = e;
    if (bad < 0) chk(name, 1'b1, 0, 0);
    else chk($sformatf("%s elem %0d", name, bad), 1'b0,
             longint'(act[bad*OW +: OW]), longint'(exp[bad*OW +: OW]));
  endtask

  task automatic start_job(input logic [AW-1:0] a, input logic [BW-1:0] b);
    @(negedge clk);
    in_1 = a; in_2 = b; in_valid = 1'b1;
    chk("in_ready before accept", in_ready_8 && in_ready_3, longint'({in_ready_8, in_ready_3}), 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_1 = rand_mat();
    in_2 = rand_mat();
    chk("busy after accept", busy_8 && busy_3 && !in_ready_8 && !in_ready_3,
        longint'({busy_8, busy_3, in_ready_8, in_ready_3}), 12);
  endtask

  task automatic wait_done();
    int              cyc;
    logic [OUTW-1:0] snap_8;
    cyc = 0; lat_8 = -1; lat_3 = -1; snap_8 = '0;
    while ((lat_8 < 0 || lat_3 < 0) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid_8 && lat_8 < 0) begin lat_8 = cyc; snap_8 = out_8; end
      if (out_valid_3 && lat_3 < 0) lat_3 = cyc;
    end
    chk("latency 8 lanes", lat_8 == 32, longint'(lat_8), 32);
    chk("latency 3 lanes", lat_3 == 88, longint'(lat_3), 88);
    chk("dut8 out held in DONE", out_8 === snap_8 && out_valid_8, longint'(out_8[63:0]), longint'(snap_8[63:0]));
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("IDLE after out_ready", in_ready_8 && in_ready_3 && !out_valid_8 && !out_valid_3,
        longint'({in_ready_8, in_ready_3, out_valid_8, out_valid_3}), 12);
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic run_job(input logic [AW-1:0] a, input logic [BW-1:0] b, input string tag);
    logic [OUTW-1:0] exp;
    exp = ref_model(a, b);
    start_job(a, b);
    wait_done();
    chk_mat({tag, " lanes8"}, out_8, exp);
    chk_mat({tag, " lanes3"}, out_3, exp);
    release_out();
  endtask

  typedef struct {
    logic [15:0] a_val;
    logic [15:0] b_val;
    bit          only0;
    logic [15:0] exp0;
    logic [15:0] exp_rest;
  } vec_t;

  vec_t            vecs [7];
  logic [AW-1:0]   ta, tb;
  logic [OUTW-1:0] texp, snap, exp2;
  bit              ok8, ok3;

  initial begin
    vecs[0] = '{16'h0100, 16'h0080, 1'b0, 16'h0200, 16'h0200};
    vecs[1] = '{16'hFF00, 16'h0080, 1'b0, 16'hFE00, 16'hFE00};
    vecs[2] = '{16'h0001, 16'h0001, 1'b1, 16'h0000, 16'h0000};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'h0000};
    vecs[4] = '{16'h7F00, 16'h7F00, 1'b0, OVF_7F,   OVF_7F};
    vecs[5] = '{16'h0080, 16'hFF80, 1'b0, 16'hFF00, 16'hFF00};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, OVF_80,   OVF_80};

    #12;
    chk("reset state", in_ready_8 && in_ready_3 && !out_valid_8 && !out_valid_3 && !busy_8 && !busy_3,
        longint'({in_ready_8, in_ready_3, out_valid_8, out_valid_3, busy_8, busy_3}), 48);
    chk("reset out zero", out_8 == '0 && out_3 == '0, longint'(out_8[63:0] | out_3[63:0]), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      ta   = fill_mat(vecs[v].a_val, vecs[v].only0);
      tb   = fill_mat(vecs[v].b_val, vecs[v].only0);
      texp = fill_out(vecs[v].exp0, vecs[v].exp_rest);
      start_job(ta, tb);
      wait_done();
      chk_mat($sformatf("vec%0d lanes8", v), out_8, texp);
      chk_mat($sformatf("vec%0d lanes3", v), out_3, texp);
      release_out();
    end

    for (int r = 0; r < 4; r++) run_job(rand_mat(), rand_mat(), $sformatf("rand%0d", r));

    // Back-pressure with a second job already offered while DONE is held.
    start_job(fill_mat(16'h0100, 1'b0), fill_mat(16'h0080, 1'b0));
    wait_done();
    ta = rand_mat(); tb = rand_mat(); exp2 = ref_model(ta, tb);
    snap = out_8; ok8 = 1'b1; ok3 = 1'b1;
    @(negedge clk);
    in_1 = ta; in_2 = tb; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!(out_valid_8 && !in_ready_8 && out_8 === snap)) ok8 = 1'b0;
      if (!(out_valid_3 && !in_ready_3 && out_3 === snap)) ok3 = 1'b0;
    end
    chk("backpressure hold lanes8", ok8, longint'(out_8[63:0]), longint'(snap[63:0]));
    chk("backpressure hold lanes3", ok3, longint'(out_3[63:0]), longint'(snap[63:0]));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bubble after release", in_ready_8 && in_ready_3 && !busy_8 && !busy_3 && !out_valid_8,
        longint'({in_ready_8, in_ready_3, busy_8, busy_3, out_valid_8}), 24);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("accept one cycle later", busy_8 && busy_3 && !in_ready_8,
        longint'({busy_8, busy_3, in_ready_8}), 6);
    in_valid = 1'b0; in_1 = rand_mat(); in_2 = rand_mat();
    wait_done();
    chk_mat("second job lanes8", out_8, exp2);
    chk_mat("second job lanes3", out_3, exp2);
    release_out();

    // Reset in the middle of COMPUTE, after the 8-lane build has written results.
    start_job(fill_mat(16'h0100, 1'b0), fill_mat(16'h0080, 1'b0));
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid reset flags", in_ready_8 && in_ready_3 && !out_valid_8 && !out_valid_3 && !busy_8 && !busy_3,
        longint'({in_ready_8, in_ready_3, out_valid_8, out_valid_3, busy_8, busy_3}), 48);
    chk("mid reset out zero", out_8 == '0 && out_3 == '0, longint'(out_8[63:0] | out_3[63:0]), 0);
    @(negedge clk); rst_n = 1'b1;
    run_job(rand_mat(), rand_mat(), "after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
